// File: rtl/obi_pkg.sv
// OBI request/response payloads shared by the tinyODIN bus fabric.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/tinyodin_obi_arbiter_pkg.sv
// Master identifiers and in-flight queue sizing for the tinyODIN OBI arbiter.
package tinyodin_obi_arbiter_pkg;

    typedef logic mst_id_t;

    localparam mst_id_t MST_CPU = 1'b0;
    localparam mst_id_t MST_DMA = 1'b1;

    localparam int unsigned MAX_OUTSTANDING_MIN = 1;
    localparam int unsigned MAX_OUTSTANDING_MAX = 4;

    // Queue storage is always sized for the largest legal depth.
    localparam int unsigned FIFO_PTR_W = $clog2(MAX_OUTSTANDING_MAX);
    localparam int unsigned FIFO_CNT_W = $clog2(MAX_OUTSTANDING_MAX + 1);

endpackage

// File: rtl/tinyodin_id_fifo.sv
// In-flight master-ID queue: synchronous push/pop with full/empty/count.
module tinyodin_id_fifo
    import tinyodin_obi_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  mst_id_t               id_i,
    output mst_id_t               id_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    mst_id_t               mem_q [MAX_OUTSTANDING_MAX];
    mst_id_t               mem_d [MAX_OUTSTANDING_MAX];
    logic                  full, empty, do_push, do_pop;

    function automatic logic [FIFO_PTR_W-1:0] ptr_next(input logic [FIFO_PTR_W-1:0] p);
        return (p == FIFO_PTR_W'(DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
    endfunction

    assign full    = (count_q == FIFO_CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = id_i;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + FIFO_CNT_W'(1);
            2'b01:   count_d = count_q - FIFO_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING_MAX); i++) begin
                mem_q[i] <= MST_CPU;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign id_o    = mem_q[rd_ptr_q];
    assign full_o  = full;
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/tinyodin_obi_arbiter.sv
// Two-master round-robin OBI arbiter in front of the tinyODIN slave port, zero-latency routing.
module tinyodin_obi_arbiter
    import tinyodin_obi_arbiter_pkg::*;
#(
    parameter type         req_t           = obi_pkg::obi_req_t,
    parameter type         rsp_t           = obi_pkg::obi_rsp_t,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic CLK,
    input  logic RSTN,
    input  req_t m0_req_i,
    output rsp_t m0_resp_o,
    input  req_t m1_req_i,
    output rsp_t m1_resp_o,
    output req_t slv_req_o,
    input  rsp_t slv_resp_i,
    output logic busy_o,
    output logic err_o
);

    mst_id_t               prio_q, prio_d;
    logic                  lock_q, lock_d;
    mst_id_t               lock_id_q, lock_id_d;
    logic                  err_q, err_d;

    logic [1:0]            req_vec;
    logic                  sel_valid;
    mst_id_t               sel_id;
    logic                  issue, accept, rsp_valid;
    logic                  fifo_full, fifo_empty;
    mst_id_t               fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;

    // A held lock keeps a stalled master on the bus until its request is taken.
    always_comb begin
        req_vec   = {m1_req_i.req, m0_req_i.req} & {2{RSTN}};
        sel_valid = 1'b0;
        sel_id    = prio_q;
        if (lock_q && req_vec[lock_id_q]) begin
            sel_valid = 1'b1;
            sel_id    = lock_id_q;
        end else if (req_vec[0] && req_vec[1]) begin
            sel_valid = 1'b1;
            sel_id    = prio_q;
        end else if (req_vec[0]) begin
            sel_valid = 1'b1;
            sel_id    = MST_CPU;
        end else if (req_vec[1]) begin
            sel_valid = 1'b1;
            sel_id    = MST_DMA;
        end
    end

    assign issue     = sel_valid & ~fifo_full;
    assign accept    = issue & slv_resp_i.gnt;
    assign rsp_valid = slv_resp_i.rvalid & ~fifo_empty & RSTN;

    always_comb begin
        slv_req_o = '0;
        m0_resp_o = '0;
        m1_resp_o = '0;
        if (issue) begin
            slv_req_o = (sel_id == MST_DMA) ? m1_req_i : m0_req_i;
        end
        m0_resp_o.gnt = accept & (sel_id == MST_CPU);
        m1_resp_o.gnt = accept & (sel_id == MST_DMA);
        if (rsp_valid) begin
            if (fifo_head == MST_DMA) begin
                m1_resp_o.rvalid = 1'b1;
                m1_resp_o.rdata  = slv_resp_i.rdata;
            end else begin
                m0_resp_o.rvalid = 1'b1;
                m0_resp_o.rdata  = slv_resp_i.rdata;
            end
        end
    end

    always_comb begin
        prio_d    = accept ? ~sel_id : prio_q;
        lock_d    = sel_valid & ~accept;
        lock_id_d = sel_id;
        err_d     = err_q | (slv_resp_i.rvalid & fifo_empty);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            prio_q    <= MST_CPU;
            lock_q    <= 1'b0;
            lock_id_q <= MST_CPU;
            err_q     <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    tinyodin_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (CLK),
        .rst_n   (RSTN),
        .push_i  (accept),
        .pop_i   (rsp_valid),
        .id_i    (sel_id),
        .id_o    (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy_o = (fifo_count != '0);
    assign err_o  = err_q;

endmodule

// File: tb/tb_tinyodin_obi_arbiter.sv
// Directed vector bench for the tinyODIN OBI arbiter.
module tb_tinyodin_obi_arbiter;
    import obi_pkg::*;

    localparam logic [31:0] M0_ADDR = 32'h0000_0100;
    localparam logic [31:0] M1_ADDR = 32'h0000_0200;

    typedef struct {
        logic        r0, r1, gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_g0, e_g1, e_v0, e_v1;
        logic [31:0] e_d0, e_d1;
        logic        e_busy, e_err;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b1;
    obi_req_t m0_req, m1_req, slv_req;
    obi_rsp_t m0_rsp, m1_rsp, slv_rsp;
    logic     busy, err;

    int checks = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t seq_lock[$];
    vec_t seq_post[$];

    always #5 clk = ~clk;

    tinyodin_obi_arbiter #(
        .req_t           (obi_req_t),
        .rsp_t           (obi_rsp_t),
        .MAX_OUTSTANDING (2)
    ) dut (
        .CLK        (clk),
        .RSTN       (rst_n),
        .m0_req_i   (m0_req),
        .m0_resp_o  (m0_rsp),
        .m1_req_i   (m1_req),
        .m1_resp_o  (m1_rsp),
        .slv_req_o  (slv_req),
        .slv_resp_i (slv_rsp),
        .busy_o     (busy),
        .err_o      (err)
    );

    function automatic vec_t mk(input logic r0, r1, gnt, rv, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_g0, e_g1, e_v0, e_v1,
                                input logic [31:0] e_d0, e_d1, input logic e_busy, e_err);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_v0 = e_v0; v.e_v1 = e_v1;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, r1, gnt, rv, input logic [31:0] rdata);
        m0_req       = '0;
        m0_req.req   = r0;
        m0_req.be    = 4'hF;
        m0_req.addr  = M0_ADDR;
        m0_req.wdata = 32'hDEAD_0000;
        m1_req       = '0;
        m1_req.req   = r1;
        m1_req.be    = 4'hF;
        m1_req.addr  = M1_ADDR;
        m1_req.wdata = 32'hBEEF_0001;
        slv_rsp        = '0;
        slv_rsp.gnt    = gnt;
        slv_rsp.rvalid = rv;
        slv_rsp.rdata  = rdata;
    endtask

    // Called just after a falling edge; samples mid-phase, then advances one cycle.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        string n;
        n = $sformatf("%s[%0d]", tag, idx);
        drive(v.r0, v.r1, v.gnt, v.rv, v.rdata);
        #2;
        chk({n, ".slv_req"},  32'(slv_req.req),    32'(v.e_req));
        chk({n, ".slv_addr"}, slv_req.addr,        v.e_addr);
        chk({n, ".m0_gnt"},   32'(m0_rsp.gnt),     32'(v.e_g0));
        chk({n, ".m1_gnt"},   32'(m1_rsp.gnt),     32'(v.e_g1));
        chk({n, ".m0_rvalid"},32'(m0_rsp.rvalid),  32'(v.e_v0));
        chk({n, ".m1_rvalid"},32'(m1_rsp.rvalid),  32'(v.e_v1));
        chk({n, ".m0_rdata"}, m0_rsp.rdata,        v.e_d0);
        chk({n, ".m1_rdata"}, m1_rsp.rdata,        v.e_d1);
        chk({n, ".busy"},     32'(busy),           32'(v.e_busy));
        chk({n, ".err"},      32'(err),            32'(v.e_err));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with all masters and the slave active: every output must read zero at once.
    task automatic do_reset(input string tag);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #2;
        chk({tag, ".busy"},      32'(busy),          32'd0);
        chk({tag, ".err"},       32'(err),           32'd0);
        chk({tag, ".slv_req"},   32'(slv_req),       32'd0);
        chk({tag, ".slv_addr"},  slv_req.addr,       32'd0);
        chk({tag, ".m0_resp"},   32'(m0_rsp),        32'd0);
        chk({tag, ".m1_resp"},   32'(m1_rsp),        32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        // Round-robin, full stall, in-order return, same-cycle push/pop, orphan rvalid.
        tbl.push_back(mk(1,1,1,0,32'd0,          1,M0_ADDR, 1,0, 0,0, 32'd0,32'd0,          0,0));
        tbl.push_back(mk(1,1,1,0,32'd0,          1,M1_ADDR, 0,1, 0,0, 32'd0,32'd0,          1,0));
        tbl.push_back(mk(1,1,1,1,32'hA5A5_0001,  0,32'd0,   0,0, 1,0, 32'hA5A5_0001,32'd0,  1,0));
        tbl.push_back(mk(1,1,1,1,32'h0000_BEEF,  1,M0_ADDR, 1,0, 0,1, 32'd0,32'h0000_BEEF,  1,0));
        tbl.push_back(mk(0,0,0,1,32'h0000_0011,  0,32'd0,   0,0, 1,0, 32'h11,32'd0,         1,0));
        tbl.push_back(mk(0,0,0,1,32'h0000_0022,  0,32'd0,   0,0, 0,0, 32'd0,32'd0,          0,0));
        tbl.push_back(mk(0,0,0,0,32'd0,          0,32'd0,   0,0, 0,0, 32'd0,32'd0,          0,1));
        tbl.push_back(mk(1,0,1,0,32'd0,          1,M0_ADDR, 1,0, 0,0, 32'd0,32'd0,          0,1));
        tbl.push_back(mk(0,0,0,1,32'h0000_0033,  0,32'd0,   0,0, 1,0, 32'h33,32'd0,         1,1));

        // m1 stalls three cycles while m0 joins; lock holds m1, then m0 follows.
        seq_lock.push_back(mk(0,1,0,0,32'd0,     1,M1_ADDR, 0,0, 0,0, 32'd0,32'd0,          0,0));
        seq_lock.push_back(mk(1,1,0,0,32'd0,     1,M1_ADDR, 0,0, 0,0, 32'd0,32'd0,          0,0));
        seq_lock.push_back(mk(1,1,0,0,32'd0,     1,M1_ADDR, 0,0, 0,0, 32'd0,32'd0,          0,0));
        seq_lock.push_back(mk(1,1,1,0,32'd0,     1,M1_ADDR, 0,1, 0,0, 32'd0,32'd0,          0,0));
        seq_lock.push_back(mk(1,1,1,0,32'd0,     1,M0_ADDR, 1,0, 0,0, 32'd0,32'd0,          1,0));
        seq_lock.push_back(mk(0,0,0,1,32'h0000_0044, 0,32'd0, 0,0, 0,1, 32'd0,32'h44,       1,0));

        // After reset mid-flight, the stale response is an error, sticky until reset.
        seq_post.push_back(mk(0,0,0,0,32'd0,     0,32'd0,   0,0, 0,0, 32'd0,32'd0,          0,0));
        seq_post.push_back(mk(0,0,0,1,32'h0000_0055, 0,32'd0, 0,0, 0,0, 32'd0,32'd0,        0,0));
        seq_post.push_back(mk(0,0,0,0,32'd0,     0,32'd0,   0,0, 0,0, 32'd0,32'd0,          0,1));
        seq_post.push_back(mk(1,0,0,0,32'd0,     1,M0_ADDR, 0,0, 0,0, 32'd0,32'd0,          0,1));

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        do_reset("reset0");
        foreach (tbl[i]) run_vec("main", i, tbl[i]);

        do_reset("reset1");
        foreach (seq_lock[i]) run_vec("lock", i, seq_lock[i]);

        do_reset("reset2");
        foreach (seq_post[i]) run_vec("post", i, seq_post[i]);

        do_reset("reset3");
        run_vec("clear", 0, mk(0,0,0,0,32'd0, 0,32'd0, 0,0, 0,0, 32'd0,32'd0, 0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
